// File: rtl/serial_reg_receiver.sv
// serial_reg_receiver: deserialises MSB-first dynamic/static register frames and validates their length
// Ports: CLK clock; RST async active-high reset; SELDYN/SELSTAT frame selects;
//   signal_in serial data (one cycle behind its select); DYNREG_OUT/STATREG_OUT last good frames;
//   DYN_VALID/STAT_VALID update pulses; FRAME_ERR bad-frame pulse; BUSY frame in progress.
// Optional: define RX_ERRCNT_EN to add ERR_CNT, a saturating count of consecutive bad frames.
module serial_reg_receiver #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN = 16,
  parameter int SIZECNT = 7
) (
  input logic CLK,
  input logic RST,
  input logic SELDYN,
  input logic SELSTAT,
  input logic signal_in,
  output logic [SIZESRDYN-1:0] DYNREG_OUT,
  output logic [SIZESRSTAT-1:0] STATREG_OUT,
  output logic DYN_VALID,
  output logic STAT_VALID,
  output logic FRAME_ERR,
  output logic BUSY
`ifdef RX_ERRCNT_EN
  ,
  output logic [7:0] ERR_CNT
`endif
);
  typedef enum logic [1:0] {IDLE, RX_DYN, RX_STAT, WAIT_IDLE} state_t;
  localparam logic [SIZECNT-1:0] DYN_LEN = SIZECNT'(SIZESRDYN);
  localparam logic [SIZECNT-1:0] STAT_LEN = SIZECNT'(SIZESRSTAT);
  state_t state;
  logic seld_d, sels_d;
  logic [SIZECNT-1:0] cnt;
  logic [SIZESRDYN-1:0] dyn_sh;
  logic [SIZESRSTAT-1:0] stat_sh;
  assign BUSY = (state == RX_DYN) || (state == RX_STAT);
  // data lags its select by one cycle, so the registered selects qualify signal_in
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      seld_d <= 1'b0;
      sels_d <= 1'b0;
      cnt <= '0;
      dyn_sh <= '0;
      stat_sh <= '0;
      DYNREG_OUT <= '0;
      STATREG_OUT <= '0;
      DYN_VALID <= 1'b0;
      STAT_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      seld_d <= SELDYN;
      sels_d <= SELSTAT;
      DYN_VALID <= 1'b0;
      STAT_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (seld_d && sels_d) begin
            FRAME_ERR <= 1'b1;
            state <= WAIT_IDLE;
          end else if (seld_d) begin
            dyn_sh <= {dyn_sh[SIZESRDYN-2:0], signal_in};
            cnt <= SIZECNT'(1);
            state <= RX_DYN;
          end else if (sels_d) begin
            stat_sh <= {stat_sh[SIZESRSTAT-2:0], signal_in};
            cnt <= SIZECNT'(1);
            state <= RX_STAT;
          end
        end
        RX_DYN: begin
          if (seld_d && sels_d) begin
            FRAME_ERR <= 1'b1;
            state <= WAIT_IDLE;
          end else if (seld_d) begin
            // past full length the count parks one above it to mark overrun
            if (cnt < DYN_LEN) begin
              dyn_sh <= {dyn_sh[SIZESRDYN-2:0], signal_in};
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= DYN_LEN + 1'b1;
            end
          end else begin
            if (cnt == DYN_LEN) begin
              DYNREG_OUT <= dyn_sh;
              DYN_VALID <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
            // back-to-back static frame: its first bit arrives on this edge
            if (sels_d) begin
              stat_sh <= {stat_sh[SIZESRSTAT-2:0], signal_in};
              cnt <= SIZECNT'(1);
              state <= RX_STAT;
            end else begin
              state <= IDLE;
            end
          end
        end
        RX_STAT: begin
          if (seld_d && sels_d) begin
            FRAME_ERR <= 1'b1;
            state <= WAIT_IDLE;
          end else if (sels_d) begin
            if (cnt < STAT_LEN) begin
              stat_sh <= {stat_sh[SIZESRSTAT-2:0], signal_in};
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= STAT_LEN + 1'b1;
            end
          end else begin
            if (cnt == STAT_LEN) begin
              STATREG_OUT <= stat_sh;
              STAT_VALID <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
            if (seld_d) begin
              dyn_sh <= {dyn_sh[SIZESRDYN-2:0], signal_in};
              cnt <= SIZECNT'(1);
              state <= RX_DYN;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT_IDLE: state <= (!seld_d && !sels_d) ? IDLE : WAIT_IDLE;
      endcase
    end
  end
`ifdef RX_ERRCNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ERR_CNT <= '0;
    else if (DYN_VALID || STAT_VALID) ERR_CNT <= '0;
    else if (FRAME_ERR && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 1'b1;
  end
`endif
endmodule

// File: tb/tb_serial_reg_receiver.sv
// tb_serial_reg_receiver: frame-level scoreboard bench for serial_reg_receiver
module tb_serial_reg_receiver;
  logic CLK = 1'b0;
  logic RST, SELDYN, SELSTAT, signal_in;
  logic [15:0] DYNREG_OUT;
  logic [87:0] STATREG_OUT;
  logic DYN_VALID, STAT_VALID, FRAME_ERR, BUSY;
`ifdef RX_ERRCNT_EN
  logic [7:0] ERR_CNT;
`endif
  serial_reg_receiver dut (
    .CLK(CLK), .RST(RST), .SELDYN(SELDYN), .SELSTAT(SELSTAT), .signal_in(signal_in),
    .DYNREG_OUT(DYNREG_OUT), .STATREG_OUT(STATREG_OUT), .DYN_VALID(DYN_VALID),
    .STAT_VALID(STAT_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
`ifdef RX_ERRCNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {logic [1:0] k; logic [127:0] v;} ev_t;
  ev_t exq[$];
  logic [1:0] q_sel[$];
  logic q_bit[$];
  int checks = 0, passed = 0, fails = 0;
  logic prev_bit = 1'b0;
  logic [127:0] m_dyn = '0, m_stat = '0;
  int m_err = 0;
  int last_kind;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input bit stat, input int len, input logic [127:0] d);
    int size;
    ev_t e;
    size = stat ? 88 : 16;
    for (int j = 0; j < len; j++) begin
      q_sel.push_back(stat ? 2'b10 : 2'b01);
      q_bit.push_back(d[len-1-j]);
    end
    e.k = (len == size) ? (stat ? 2'd1 : 2'd0) : 2'd2;
    e.v = stat ? {40'b0, d[87:0]} : {112'b0, d[15:0]};
    exq.push_back(e);
  endtask
  task automatic gap(input int n);
    for (int j = 0; j < n; j++) begin
      q_sel.push_back(2'b00);
      q_bit.push_back(1'b0);
    end
  endtask
  task automatic sample();
    int n, code;
    ev_t e;
    n = int'(DYN_VALID) + int'(STAT_VALID) + int'(FRAME_ERR);
    if (n != 0) begin
      chk("single_pulse", n, 1);
      chk("event_expected", exq.size() > 0, 1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        code = DYN_VALID ? 0 : STAT_VALID ? 1 : 2;
        chk("event_kind", code, e.k);
        if (e.k == 2'd0) begin
          m_dyn = e.v;
          m_err = 0;
        end else if (e.k == 2'd1) begin
          m_stat = e.v;
          m_err = 0;
        end else if (m_err < 255) m_err++;
        chk("dynreg", DYNREG_OUT, m_dyn);
        chk("statreg", STATREG_OUT, m_stat);
      end
    end
  endtask
  task automatic tick_drive(input logic [1:0] s, input logic b);
    @(negedge CLK);
    sample();
    SELDYN = s[0];
    SELSTAT = s[1];
    signal_in = prev_bit;
    prev_bit = b;
  endtask
  task automatic drive_queue();
    while (q_sel.size() > 0) tick_drive(q_sel.pop_front(), q_bit.pop_front());
  endtask
  task automatic play();
    drive_queue();
    for (int j = 0; j < 6; j++) tick_drive(2'b00, 1'b0);
    chk("busy_idle", BUSY, 0);
    chk("events_drained", exq.size(), 0);
`ifdef RX_ERRCNT_EN
    chk("err_cnt", ERR_CNT, m_err);
`endif
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    RST = 1'b1;
    SELDYN = 1'b0;
    SELSTAT = 1'b0;
    signal_in = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_dynreg", DYNREG_OUT, 0);
    chk("rst_statreg", STATREG_OUT, 0);
    chk("rst_pulses", {DYN_VALID, STAT_VALID, FRAME_ERR, BUSY}, 0);
`ifdef RX_ERRCNT_EN
    chk("rst_err_cnt", ERR_CNT, 0);
`endif
    RST = 1'b0;
    frame(0, 16, 128'hABCD);
    gap(3);
    play();
    frame(1, 88, 128'h123456789ABCDEF1234567);
    gap(3);
    play();
    frame(0, 15, rnd());
    gap(3);
    frame(0, 17, rnd());
    gap(2);
    frame(1, 87, rnd());
    gap(3);
    play();
    frame(0, 16, 128'h0F0F);
    gap(3);
    play();
    frame(0, 16, 128'h1234);
    frame(1, 88, rnd());
    gap(3);
    play();
    begin
      ev_t e;
      for (int j = 0; j < 4; j++) begin
        q_sel.push_back(2'b01);
        q_bit.push_back(1'($urandom));
      end
      q_sel.push_back(2'b11);
      q_bit.push_back(1'b1);
      for (int j = 0; j < 3; j++) begin
        q_sel.push_back(2'b01);
        q_bit.push_back(1'($urandom));
      end
      e.k = 2'd2;
      e.v = '0;
      exq.push_back(e);
    end
    gap(3);
    frame(0, 16, 128'h5A5A);
    gap(3);
    play();
    for (int j = 0; j < 40; j++) begin
      q_sel.push_back(2'b10);
      q_bit.push_back(1'($urandom));
    end
    drive_queue();
    #2;
    chk("busy_mid_frame", BUSY, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_dynreg", DYNREG_OUT, 0);
    chk("rst_mid_statreg", STATREG_OUT, 0);
    chk("rst_mid_flags", {DYN_VALID, STAT_VALID, FRAME_ERR, BUSY}, 0);
    m_dyn = '0;
    m_stat = '0;
    m_err = 0;
    SELDYN = 1'b0;
    SELSTAT = 1'b0;
    signal_in = 1'b0;
    prev_bit = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_hold_flags", {DYN_VALID, STAT_VALID, FRAME_ERR, BUSY}, 0);
    RST = 1'b0;
    frame(0, 16, 128'hC3A5);
    gap(3);
    play();
    last_kind = 2;
    for (int f = 0; f < 40; f++) begin
      int stat, size, len, r, g;
      stat = $urandom_range(0, 1);
      size = stat ? 88 : 16;
      r = $urandom_range(0, 3);
      len = (r < 2) ? size : (r == 2) ? ($urandom_range(0, 1) ? size - 1 : size + 1) : $urandom_range(1, size + 3);
      g = (stat == last_kind) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      gap(g);
      frame(stat[0], len, rnd());
      last_kind = stat;
    end
    gap(3);
    play();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
